// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: shared edge/center-aligned period counter, per-channel compare and polarity,
// with double-buffered configuration that goes live only at a period boundary.
module pwm_multi_channel #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en_i,
  input  logic                      wr_en_i,
  input  logic                      wr_mode_i,
  input  logic [WIDTH-1:0]          wr_period_i,
  input  logic [CHANNELS*WIDTH-1:0] wr_duty_i,
  input  logic [CHANNELS-1:0]       wr_pol_i,
  output logic [CHANNELS-1:0]       pwm_out_o,
  output logic [WIDTH-1:0]          cnt_o,
  output logic                      period_end_o,
  output logic                      upd_pend_o
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0]          cnt_q, cnt_d;
  logic                      dir_down_q, dir_down_d;
  logic                      sh_mode_q;
  logic [WIDTH-1:0]          sh_period_q;
  logic [CHANNELS*WIDTH-1:0] sh_duty_q;
  logic [CHANNELS-1:0]       sh_pol_q;
  logic                      lv_mode_q;
  logic [WIDTH-1:0]          lv_period_q;
  logic [CHANNELS*WIDTH-1:0] lv_duty_q;
  logic [CHANNELS-1:0]       lv_pol_q;
  logic                      upd_pend_q, upd_pend_d;
  logic [CHANNELS-1:0]       pwm_q, pwm_d;
  logic                      period_end_q;

  logic             boundary;
  logic             xfer;
  logic [WIDTH-1:0] next_period;

  // Center mode only closes a period on the way down, so the 0 at start-up is not a boundary.
  assign boundary = en_i & (lv_mode_q ? ((cnt_q == ZERO) & (dir_down_q | (lv_period_q == ZERO)))
                                      : (cnt_q == lv_period_q));
  assign xfer        = (boundary | ~en_i) & upd_pend_q;
  assign next_period = upd_pend_q ? sh_period_q : lv_period_q;

  always_comb begin
    cnt_d      = cnt_q;
    dir_down_d = dir_down_q;
    if (!en_i) begin
      cnt_d      = ZERO;
      dir_down_d = 1'b0;
    end else if (boundary) begin
      // Center boundary sits at 0, which already belongs to the new period: step on to 1.
      dir_down_d = 1'b0;
      cnt_d      = (lv_mode_q && next_period != ZERO) ? ONE : ZERO;
    end else if (!lv_mode_q) begin
      cnt_d = cnt_q + ONE;
    end else if (!dir_down_q) begin
      if (cnt_q == lv_period_q) begin
        cnt_d      = cnt_q - ONE;
        dir_down_d = 1'b1;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_comb begin
    upd_pend_d = upd_pend_q;
    if (wr_en_i) begin
      upd_pend_d = 1'b1;
    end else if (boundary || !en_i) begin
      upd_pend_d = 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_cmp
      logic raw;
      assign raw       = cnt_q < lv_duty_q[gi*WIDTH +: WIDTH];
      assign pwm_d[gi] = en_i ? (raw ^ lv_pol_q[gi]) : lv_pol_q[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      dir_down_q   <= 1'b0;
      sh_mode_q    <= 1'b0;
      sh_period_q  <= '0;
      sh_duty_q    <= '0;
      sh_pol_q     <= '0;
      lv_mode_q    <= 1'b0;
      lv_period_q  <= '0;
      lv_duty_q    <= '0;
      lv_pol_q     <= '0;
      upd_pend_q   <= 1'b0;
      pwm_q        <= '0;
      period_end_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      dir_down_q   <= dir_down_d;
      upd_pend_q   <= upd_pend_d;
      pwm_q        <= pwm_d;
      period_end_q <= boundary;
      if (wr_en_i) begin
        sh_mode_q   <= wr_mode_i;
        sh_period_q <= wr_period_i;
        sh_duty_q   <= wr_duty_i;
        sh_pol_q    <= wr_pol_i;
      end
      // Transfer reads the pre-write shadow when a write coincides with the boundary.
      if (xfer) begin
        lv_mode_q   <= sh_mode_q;
        lv_period_q <= sh_period_q;
        lv_duty_q   <= sh_duty_q;
        lv_pol_q    <= sh_pol_q;
      end
    end
  end

  assign pwm_out_o    = pwm_q;
  assign cnt_o        = cnt_q;
  assign period_end_o = period_end_q;
  assign upd_pend_o   = upd_pend_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Randomized bench for pwm_multi_channel against a position-in-period reference model.
module tb_pwm_multi_channel;
  localparam int W  = 16;
  localparam int CH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            en_i, wr_en_i, wr_mode_i;
  logic [W-1:0]    wr_period_i;
  logic [CH*W-1:0] wr_duty_i;
  logic [CH-1:0]   wr_pol_i;
  logic [CH-1:0]   pwm_out_o;
  logic [W-1:0]    cnt_o;
  logic            period_end_o, upd_pend_o;

  pwm_multi_channel #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .wr_en_i(wr_en_i), .wr_mode_i(wr_mode_i),
    .wr_period_i(wr_period_i), .wr_duty_i(wr_duty_i), .wr_pol_i(wr_pol_i),
    .pwm_out_o(pwm_out_o), .cnt_o(cnt_o), .period_end_o(period_end_o), .upd_pend_o(upd_pend_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: time since period start (pos) plus live/shadow config.
  int          pos;
  bit          m_mode, s_mode;
  int          m_p, s_p;
  int          m_duty[CH], s_duty[CH];
  bit [CH-1:0] m_pol, s_pol;
  bit          m_pend, m_pe;
  bit [CH-1:0] m_pwm;

  function automatic int model_cnt();
    int m;
    if (m_p == 0) return 0;
    if (!m_mode) return pos;
    m = pos % (2 * m_p);
    return (m <= m_p) ? m : 2 * m_p - m;
  endfunction

  function automatic bit model_boundary(input bit en);
    if (!en) return 1'b0;
    if (m_p == 0) return 1'b1;
    if (!m_mode) return pos == m_p;
    return (pos > 0) && (pos % (2 * m_p) == 0);
  endfunction

  task automatic model_reset();
    pos = 0; m_mode = 0; s_mode = 0; m_p = 0; s_p = 0;
    m_pol = '0; s_pol = '0; m_pend = 0; m_pe = 0; m_pwm = '0;
    for (int i = 0; i < CH; i++) begin
      m_duty[i] = 0;
      s_duty[i] = 0;
    end
  endtask

  task automatic model_step();
    int  c, pnew;
    bit  b;
    c = model_cnt();
    b = model_boundary(en_i);
    for (int i = 0; i < CH; i++)
      m_pwm[i] = en_i ? ((c < m_duty[i]) ^ m_pol[i]) : m_pol[i];
    m_pe = b;
    if (!en_i) begin
      pos = 0;
    end else if (b) begin
      pnew = m_pend ? s_p : m_p;
      pos  = (!m_mode || pnew == 0) ? 0 : 1;
    end else begin
      pos++;
    end
    if ((b || !en_i) && m_pend) begin
      m_mode = s_mode; m_p = s_p; m_pol = s_pol;
      for (int i = 0; i < CH; i++) m_duty[i] = s_duty[i];
    end
    if (wr_en_i) begin
      m_pend = 1'b1;
      s_mode = wr_mode_i; s_p = int'(wr_period_i); s_pol = wr_pol_i;
      for (int i = 0; i < CH; i++) s_duty[i] = int'(wr_duty_i[i*W +: W]);
    end else if (b || !en_i) begin
      m_pend = 1'b0;
    end
  endtask

  task automatic check_outputs();
    check_eq("cnt", int'(cnt_o), model_cnt());
    check_eq("pwm", int'(pwm_out_o), int'(m_pwm));
    check_eq("period_end", int'(period_end_o), int'(m_pe));
    check_eq("upd_pend", int'(upd_pend_o), int'(m_pend));
  endtask

  task automatic randomize_inputs();
    int r;
    en_i        = ($urandom_range(0, 59) != 0);
    wr_en_i     = ($urandom_range(0, 19) == 0);
    wr_mode_i   = 1'($urandom_range(0, 1));
    wr_period_i = W'($urandom_range(0, 12));
    wr_pol_i    = CH'($urandom_range(0, 15));
    for (int i = 0; i < CH; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      wr_duty_i[i*W +: W] = '0;
      else if (r == 1) wr_duty_i[i*W +: W] = 16'hFFFF;
      else             wr_duty_i[i*W +: W] = W'($urandom_range(0, 14));
    end
  endtask

  initial begin
    rst = 1'b1; en_i = 0; wr_en_i = 0; wr_mode_i = 0;
    wr_period_i = '0; wr_duty_i = '0; wr_pol_i = '0;
    model_reset();
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
    randomize_inputs();
    model_step();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      check_outputs();
      if (cyc == 2000 || cyc == 3100) begin
        #1 rst = 1'b1;
        #1;
        check_eq("rst_cnt", int'(cnt_o), 0);
        check_eq("rst_pwm", int'(pwm_out_o), 0);
        check_eq("rst_pe", int'(period_end_o), 0);
        check_eq("rst_pend", int'(upd_pend_o), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
      end
      randomize_inputs();
      model_step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
